if_id_reg: RTL and testbench
============================

IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 The block SHALL use clock clk and reset reset, synchronous, active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 en  input  1  1 = advance F→D this cycle; 0 = stall (hold D).
REQ-005 flush  input  1  1 = load a bubble into D (exception/eret redirect).
REQ-006 pcF  input  32  fetch-stage PC from the PC register.
REQ-007 instrF  input  32  instruction word read from IM at pcF.
REQ-008 bdF  input  1  fetched instruction occupies a branch delay slot.
REQ-009 pcD  output  32  registered PC of the instruction in D.
REQ-010 instrD  output  32  registered instruction word in D.
REQ-011 bdD  output  1  registered delay-slot flag.
REQ-012 excCodeD  output  5  registered fetch exception code (0 = none, 4 = AdEL).
REQ-013 validD  output  1  1 = D holds a real instruction, 0 = bubble.
REQ-014 stallCnt  output  32  count of cycles with en=0 and flush=0 since reset.

Function
REQ-015 All outputs SHALL be registered; one-cycle latency F→D on load.
REQ-016 Update priority SHALL be: reset > flush > en=0 hold > load.
REQ-017 Load (en=1, flush=0): pcD←pcF, bdD←bdF, validD←1, instrD/excCodeD per REQ-019/020.
REQ-018 Hold (en=0, flush=0): every D output SHALL keep its value; stallCnt increments by 1.
REQ-019 Fetch check: pcF[1:0]≠0, pcF<0x00003000 or pcF>0x00006FFC SHALL flag AdEL.
REQ-020 On AdEL load: instrD←0x00000000, excCodeD←4, validD←1, pcD←pcF; else instrD←instrF, excCodeD←0.
REQ-021 Flush (regardless of en): instrD←0, excCodeD←0, bdD←0, validD←0, pcD←pcF.
REQ-022 Flush with en=0 SHALL NOT increment stallCnt.
REQ-023 stallCnt SHALL wrap 0xFFFFFFFF→0 with no flag.
REQ-024 Boundary pcF=0x00006FFC SHALL be legal; 0x00007000 SHALL raise AdEL.
REQ-025 No output SHALL depend combinationally on any input.

Reset
REQ-026 On reset: pcD=0x00003000, instrD=0, bdD=0, excCodeD=0, validD=0, stallCnt=0.
REQ-027 Reset asserted mid-stall or coincident with flush SHALL yield exactly the REQ-026 values next edge.
REQ-028 Power-up (initial) values SHALL equal the reset values.

Structure
REQ-029 Shared package SHALL hold PC_RESET=0x00003000, IM_LO=0x00003000, IM_HI=0x00006FFC, EXC_NONE=0, EXC_ADEL=4, NOP=0.
REQ-030 The address check SHALL be a combinational sub-module fetch_exc_chk (pcF in, adel out), reusable by M-stage load/store checks.

Verification
REQ-031 Reset, then pcF=0x3000, instrF=0x24080001, en=1 → next edge pcD=0x3000, instrD=0x24080001, validD=1, excCodeD=0.
REQ-032 en=0 for 3 cycles with changing pcF/instrF → D outputs frozen, stallCnt=3.
REQ-033 flush=1, en=0, pcF=0x4180 → instrD=0, validD=0, bdD=0, pcD=0x4180, stallCnt unchanged.
REQ-034 pcF=0x3002, then 0x7000, then 0x6FFC (en=1) → excCodeD=4,4,0; instrD=0,0,instrF.
REQ-035 Load with bdF=1, then reset=1 with flush=1 → bdD=1 then all REQ-026 values.

Source files
------------

// File: rtl/if_id_reg_pkg.sv
// Shared constants and the D-stage payload type for the IF/ID pipeline register.
package if_id_reg_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned EXC_W   = 5;

    localparam logic [XLEN-1:0]  PC_RESET = 32'h0000_3000;
    localparam logic [XLEN-1:0]  IM_LO    = 32'h0000_3000;
    localparam logic [XLEN-1:0]  IM_HI    = 32'h0000_6FFC;
    localparam logic [EXC_W-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [XLEN-1:0]  NOP      = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        logic             bd;
        logic [EXC_W-1:0] exc_code;
        logic             valid;
    } d_stage_t;

    localparam d_stage_t D_RESET = '{
        pc:       PC_RESET,
        instr:    NOP,
        bd:       1'b0,
        exc_code: EXC_NONE,
        valid:    1'b0
    };

endpackage

// File: rtl/fetch_exc_chk.sv
// Combinational instruction-address check: flags AdEL for misaligned or out-of-IM addresses.
module fetch_exc_chk
    import if_id_reg_pkg::*;
(
    input  logic [XLEN-1:0] pcF,
    output logic            adel
);

    always_comb begin
        adel = 1'b0;
        if ((pcF[1:0] != 2'b00) || (pcF < IM_LO) || (pcF > IM_HI)) begin
            adel = 1'b1;
        end
    end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall, flush, fetch-address exception tagging and stall counter.
module if_id_reg
    import if_id_reg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic [XLEN-1:0]   pcF,
    input  logic [XLEN-1:0]   instrF,
    input  logic              bdF,
    output logic [XLEN-1:0]   pcD,
    output logic [XLEN-1:0]   instrD,
    output logic              bdD,
    output logic [EXC_W-1:0]  excCodeD,
    output logic              validD,
    output logic [XLEN-1:0]   stallCnt
);

    // Power-up contents match the reset contents.
    d_stage_t        d_q       = D_RESET;
    logic [XLEN-1:0] stall_q   = '0;
    d_stage_t        load_c;
    d_stage_t        bubble_c;
    logic            adel_c;

    fetch_exc_chk u_fetch_exc_chk (
        .pcF  (pcF),
        .adel (adel_c)
    );

    // Next D contents for a normal load and for a flush bubble.
    always_comb begin
        load_c          = D_RESET;
        load_c.pc       = pcF;
        load_c.bd       = bdF;
        load_c.valid    = 1'b1;
        load_c.instr    = adel_c ? NOP : instrF;
        load_c.exc_code = adel_c ? EXC_ADEL : EXC_NONE;

        bubble_c        = D_RESET;
        bubble_c.pc     = pcF;
    end

    // Priority: reset, flush, stall, load.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q     <= D_RESET;
            stall_q <= '0;
        end else if (flush) begin
            d_q     <= bubble_c;
        end else if (!en) begin
            stall_q <= stall_q + XLEN'(1);
        end else begin
            d_q     <= load_c;
        end
    end

    assign pcD      = d_q.pc;
    assign instrD   = d_q.instr;
    assign bdD      = d_q.bd;
    assign excCodeD = d_q.exc_code;
    assign validD   = d_q.valid;
    assign stallCnt = stall_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed scenarios followed by random traffic against a reference model.
module tb_if_id_reg;

    logic        clk;
    logic        reset;
    logic        en;
    logic        flush;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic        bdF;
    logic [31:0] pcD;
    logic [31:0] instrD;
    logic        bdD;
    logic [4:0]  excCodeD;
    logic        validD;
    logic [31:0] stallCnt;

    if_id_reg dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .flush    (flush),
        .pcF      (pcF),
        .instrF   (instrF),
        .bdF      (bdF),
        .pcD      (pcD),
        .instrD   (instrD),
        .bdD      (bdD),
        .excCodeD (excCodeD),
        .validD   (validD),
        .stallCnt (stallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned passes = 0;

    // Reference model state: what D should hold.
    logic [31:0] m_pc    = 32'h3000;
    logic [31:0] m_instr = 32'h0;
    logic        m_bd    = 1'b0;
    logic [4:0]  m_exc   = 5'd0;
    logic        m_valid = 1'b0;
    logic [31:0] m_stall = 32'h0;

    function automatic bit is_adel(input logic [31:0] p);
        return (p % 4 != 0) || (p < 32'h3000) || (p > 32'h6FFC);
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic f,
                              input logic [31:0] p, input logic [31:0] i, input logic b);
        if (r) begin
            m_pc = 32'h3000; m_instr = 0; m_bd = 0; m_exc = 0; m_valid = 0; m_stall = 0;
        end else if (f) begin
            m_pc = p; m_instr = 0; m_bd = 0; m_exc = 0; m_valid = 0;
        end else if (!e) begin
            m_stall = m_stall + 1;
        end else begin
            m_pc = p; m_bd = b; m_valid = 1;
            if (is_adel(p)) begin
                m_instr = 0; m_exc = 4;
            end else begin
                m_instr = i; m_exc = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pcD"},      pcD,               m_pc);
        check({tag, ".instrD"},   instrD,            m_instr);
        check({tag, ".bdD"},      32'(bdD),          32'(m_bd));
        check({tag, ".excCodeD"}, 32'(excCodeD),     32'(m_exc));
        check({tag, ".validD"},   32'(validD),       32'(m_valid));
        check({tag, ".stallCnt"}, stallCnt,          m_stall);
    endtask

    task automatic step(input string tag, input logic r, input logic e, input logic f,
                        input logic [31:0] p, input logic [31:0] i, input logic b);
        reset = r; en = e; flush = f; pcF = p; instrF = i; bdF = b;
        @(posedge clk);
        model_edge(r, e, f, p, i, b);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] frz_pc;
        logic [31:0] frz_instr;
        logic [31:0] rp;
        int unsigned sel;

        reset = 1'b0; en = 1'b0; flush = 1'b0; pcF = 32'h0; instrF = 32'h0; bdF = 1'b0;
        #1;
        check_all("powerup");

        step("reset", 1, 0, 0, 32'h1234, 32'hDEAD_BEEF, 1);
        step("load0", 0, 1, 0, 32'h3000, 32'h2408_0001, 0);
        check("load0.pcD.const",   pcD,    32'h3000);
        check("load0.instr.const", instrD, 32'h2408_0001);

        frz_pc = pcD; frz_instr = instrD;
        step("stall1", 0, 0, 0, 32'h3004, 32'h1111_1111, 1);
        step("stall2", 0, 0, 0, 32'h3008, 32'h2222_2222, 0);
        step("stall3", 0, 0, 0, 32'h300C, 32'h3333_3333, 1);
        check("stall.frozen.pc",    pcD,      frz_pc);
        check("stall.frozen.instr", instrD,   frz_instr);
        check("stall.count3",       stallCnt, 32'd3);

        step("flush_en0", 0, 0, 1, 32'h4180, 32'h5555_5555, 1);
        check("flush.pcD.const",   pcD,      32'h4180);
        check("flush.stall.const", stallCnt, 32'd3);
        step("flush_en1", 0, 1, 1, 32'h4184, 32'h6666_6666, 1);

        step("adel_misalign", 0, 1, 0, 32'h3002, 32'hAAAA_0001, 0);
        check("adel_misalign.exc", 32'(excCodeD), 32'd4);
        step("adel_7000",     0, 1, 0, 32'h7000, 32'hAAAA_0002, 0);
        check("adel_7000.exc",     32'(excCodeD), 32'd4);
        step("legal_6ffc",    0, 1, 0, 32'h6FFC, 32'hAAAA_0003, 0);
        check("legal_6ffc.instr",  instrD, 32'hAAAA_0003);
        step("adel_low",      0, 1, 0, 32'h2FFC, 32'hAAAA_0004, 1);

        step("bd_load",  0, 1, 0, 32'h3010, 32'h0000_0008, 1);
        check("bd_load.bdD", 32'(bdD), 32'd1);
        step("stall_pre_rst", 0, 0, 0, 32'h3014, 32'h0, 0);
        step("rst_flush", 1, 1, 1, 32'h5000, 32'h7777_7777, 1);
        check("rst_flush.pcD", pcD, 32'h3000);

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       rp = 32'h6FFC + 32'($urandom_range(0, 8));
                1:       rp = 32'h2FF8 + 32'($urandom_range(0, 12));
                2:       rp = $urandom;
                default: rp = 32'h3000 + 32'($urandom_range(0, 32'h3FFF));
            endcase
            step("rand", ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), rp, $urandom, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
